// File: rtl/machine_trap_unit.sv
// machine_trap_unit
// M-mode CSR file and trap sequencer. Holds mstatus/misa/mie/mtvec/mscratch/
// mepc/mcause/mtval/mip, arbitrates exceptions against interrupts and walks
// trap entry / MRET through IDLE -> ENTER|RETURN -> REDIRECT, producing a
// one-cycle redirect pulse two cycles after the triggering event.
//
// Ports:
//   clock_i, reset_ni            clock, asynchronous active-low reset
//   csr_address_i/command_i      CSR access (00 none, 01 R, 10 W, 11 RW)
//   csr_write_data_i             write data, applied at the next edge
//   csr_read_data_o              combinational read data (0 when not reading)
//   csr_read_data_valid_o        address implemented and sequencer idle
//   csr_illegal_o                access to an unimplemented address
//   exception_i/_cause_i/_tval_i synchronous exception from commit
//   commit_pc_i                  PC of the committing instruction
//   mret_i                       MRET at commit
//   irq_i                        {meip, mtip, msip}
//   local_irq_i                  platform-local interrupts (mip bit 16+i)
//   trap_taken_o, trap_pc_o      redirect pulse and target
//   busy_o                       sequencer active, commit must stall
//
// Build option: define MTVEC_VECTORED_EN to make mtvec.mode writable and
// send interrupts to base + 4*code when mode is 1.
module machine_trap_unit #(
  parameter int          XLEN          = 64,
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [63:0] BOOT_ADDRESS  = 64'h8000_0000
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic [11:0]              csr_address_i,
  input  logic [1:0]               csr_command_i,
  input  logic [XLEN-1:0]          csr_write_data_i,
  output logic [XLEN-1:0]          csr_read_data_o,
  output logic                     csr_read_data_valid_o,
  output logic                     csr_illegal_o,
  input  logic                     exception_i,
  input  logic [4:0]               exception_cause_i,
  input  logic [XLEN-1:0]          exception_tval_i,
  input  logic [XLEN-1:0]          commit_pc_i,
  input  logic                     mret_i,
  input  logic [2:0]               irq_i,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq_i,
  output logic                     trap_taken_o,
  output logic [XLEN-1:0]          trap_pc_o,
  output logic                     busy_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] MISA_VALUE =
    {((XLEN == 64) ? 2'd2 : 2'd1), {(XLEN-11){1'b0}}, 9'h100};
  localparam logic [XLEN-1:0] PC_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  function automatic logic [XLEN-1:0] interrupt_mask();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [XLEN-1:0] MIE_MASK = interrupt_mask();

  typedef enum logic [1:0] {ST_IDLE, ST_ENTER, ST_RETURN, ST_REDIRECT} state_t;

  state_t            state_q, state_d;
  logic              mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0]   mie_q, mip_q, mip_d;
  logic [XLEN-3:0]   mtvec_base_q;
  logic              mtvec_mode;
  logic [XLEN-1:0]   mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0]   cause_q, tval_q, target_q, trap_target;
  logic [XLEN-1:0]   pending, csr_value;
  logic [4:0]        irq_code;
  logic              irq_any, csr_implemented, csr_write_en, csr_read_en;

`ifdef MTVEC_VECTORED_EN
  logic mtvec_mode_q;
  assign mtvec_mode = mtvec_mode_q;
`else
  assign mtvec_mode = 1'b0;
`endif

  // Registered copy of the interrupt lines, as seen through mip.
  always_comb begin
    mip_d     = '0;
    mip_d[3]  = irq_i[0];
    mip_d[7]  = irq_i[1];
    mip_d[11] = irq_i[2];
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_d[16+i] = local_irq_i[i];
  end

  // Interrupt arbitration: MEI > MSI > MTI > locals; the upward scan lets
  // the highest local index overwrite lower ones.
  assign pending = mip_q & mie_q & {XLEN{mstatus_mie_q}};
  assign irq_any = |pending;

  always_comb begin
    irq_code = 5'd0;
    if (pending[11])     irq_code = 5'd11;
    else if (pending[3]) irq_code = 5'd3;
    else if (pending[7]) irq_code = 5'd7;
    else begin
      for (int i = 0; i < NUM_LOCAL_IRQ; i++)
        if (pending[16+i]) irq_code = 5'(16 + i);
    end
  end

  // CSR decode and read mux
  always_comb begin
    csr_implemented = 1'b1;
    csr_value       = '0;
    case (csr_address_i)
      ADDR_MSTATUS: begin
        csr_value[12:11] = 2'b11;
        csr_value[7]     = mstatus_mpie_q;
        csr_value[3]     = mstatus_mie_q;
      end
      ADDR_MISA:     csr_value = MISA_VALUE;
      ADDR_MIE:      csr_value = mie_q;
      ADDR_MTVEC:    csr_value = {mtvec_base_q, 1'b0, mtvec_mode};
      ADDR_MSCRATCH: csr_value = mscratch_q;
      ADDR_MEPC:     csr_value = mepc_q;
      ADDR_MCAUSE:   csr_value = mcause_q;
      ADDR_MTVAL:    csr_value = mtval_q;
      ADDR_MIP:      csr_value = mip_q;
      default:       csr_implemented = 1'b0;
    endcase
  end

  assign csr_read_en           = (csr_command_i == 2'b01) || (csr_command_i == 2'b11);
  assign csr_read_data_o       = (csr_read_en && csr_implemented && !busy_o) ? csr_value : '0;
  assign csr_read_data_valid_o = csr_implemented && (state_q == ST_IDLE);
  assign csr_illegal_o         = (csr_command_i != 2'b00) && !csr_implemented;
  assign csr_write_en          = csr_command_i[1] && csr_implemented && !busy_o && !exception_i;

  // Vectoring applies to interrupts only; exceptions always land on base.
  always_comb begin
    trap_target = {mtvec_base_q, 2'b00};
    if (cause_q[XLEN-1] && mtvec_mode)
      trap_target = {mtvec_base_q, 2'b00} + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
  end

  // Sequencer: next state and outputs
  always_comb begin
    state_d      = state_q;
    busy_o       = (state_q != ST_IDLE);
    trap_taken_o = 1'b0;
    trap_pc_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (exception_i || irq_any) state_d = ST_ENTER;
        else if (mret_i)            state_d = ST_RETURN;
      end
      ST_ENTER, ST_RETURN: state_d = ST_REDIRECT;
      ST_REDIRECT: begin
        state_d      = ST_IDLE;
        trap_taken_o = 1'b1;
        trap_pc_o    = target_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Stage 1 capture (IDLE): cause/tval of whatever wins this cycle.
  // Stage 2 capture (ENTER/RETURN): redirect target.
  always_ff @(posedge clock_i) begin
    if (state_q == ST_IDLE) begin
      if (exception_i) begin
        cause_q <= {{(XLEN-5){1'b0}}, exception_cause_i};
        tval_q  <= exception_tval_i;
      end else begin
        cause_q <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
        tval_q  <= '0;
      end
    end
    if (state_q == ST_ENTER)       target_q <= trap_target;
    else if (state_q == ST_RETURN) target_q <= mepc_q;
  end

  // Architectural CSR state; software writes only happen in IDLE, so they
  // never collide with the ENTER/RETURN updates.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_base_q   <= BOOT_ADDRESS[XLEN-1:2];
`ifdef MTVEC_VECTORED_EN
      mtvec_mode_q   <= 1'b0;
`endif
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mip_q <= mip_d;
      if (csr_write_en) begin
        case (csr_address_i)
          ADDR_MSTATUS: begin
            mstatus_mie_q  <= csr_write_data_i[3];
            mstatus_mpie_q <= csr_write_data_i[7];
          end
          ADDR_MIE: mie_q <= csr_write_data_i & MIE_MASK;
          ADDR_MTVEC: begin
            mtvec_base_q <= csr_write_data_i[XLEN-1:2];
`ifdef MTVEC_VECTORED_EN
            // Reserved modes 2/3 keep the current mode.
            if (!csr_write_data_i[1]) mtvec_mode_q <= csr_write_data_i[0];
`endif
          end
          ADDR_MSCRATCH: mscratch_q <= csr_write_data_i;
          ADDR_MEPC:     mepc_q     <= csr_write_data_i & PC_MASK;
          ADDR_MCAUSE:   mcause_q   <= csr_write_data_i;
          ADDR_MTVAL:    mtval_q    <= csr_write_data_i;
          default: ;
        endcase
      end
      if (state_q == ST_ENTER) begin
        mepc_q         <= commit_pc_i & PC_MASK;
        mcause_q       <= cause_q;
        mtval_q        <= tval_q;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (state_q == ST_RETURN) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_machine_trap_unit.sv
// Bench for machine_trap_unit (XLEN=64, four local interrupts). A cycle
// model of the architectural CSRs and trap timing is compared against the
// DUT on every falling edge; directed scenarios add literal expectations.
module tb_machine_trap_unit;
  localparam int NL = 4;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [11:0] csr_address_i = '0;
  logic [1:0]  csr_command_i = '0;
  logic [63:0] csr_write_data_i = '0;
  logic [63:0] csr_read_data_o;
  logic        csr_read_data_valid_o, csr_illegal_o;
  logic        exception_i = 1'b0;
  logic [4:0]  exception_cause_i = '0;
  logic [63:0] exception_tval_i = '0;
  logic [63:0] commit_pc_i = '0;
  logic        mret_i = 1'b0;
  logic [2:0]  irq_i = '0;
  logic [NL-1:0] local_irq_i = '0;
  logic        trap_taken_o;
  logic [63:0] trap_pc_o;
  logic        busy_o;

  machine_trap_unit #(.XLEN(64), .NUM_LOCAL_IRQ(NL), .BOOT_ADDRESS(64'h8000_0000)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni),
    .csr_address_i(csr_address_i), .csr_command_i(csr_command_i),
    .csr_write_data_i(csr_write_data_i), .csr_read_data_o(csr_read_data_o),
    .csr_read_data_valid_o(csr_read_data_valid_o), .csr_illegal_o(csr_illegal_o),
    .exception_i(exception_i), .exception_cause_i(exception_cause_i),
    .exception_tval_i(exception_tval_i), .commit_pc_i(commit_pc_i),
    .mret_i(mret_i), .irq_i(irq_i), .local_irq_i(local_irq_i),
    .trap_taken_o(trap_taken_o), .trap_pc_o(trap_pc_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_ie, m_pie, m_tvec_mode, m_is_ret;
  logic [63:0] m_mie, m_tvec_base, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  logic [63:0] m_cause, m_tval, m_target;
  int          m_phase;   // cycles into a trap sequence; 0 = idle

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                     12'h341, 12'h342, 12'h343, 12'h344};
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 | {56'b0, m_pie, 3'b0, m_ie, 3'b0};
      12'h301: return 64'h8000_0000_0000_0100;
      12'h304: return m_mie;
      12'h305: return m_tvec_base | {63'b0, m_tvec_mode};
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      default: return 64'h0;
    endcase
  endfunction

  function automatic int m_prio(input logic [63:0] p);
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    for (int i = NL - 1; i >= 0; i--) if (p[16+i]) return 16 + i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ie = 0; m_pie = 0; m_mie = 0; m_tvec_base = 64'h8000_0000; m_tvec_mode = 0;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0;
    m_phase = 0; m_is_ret = 0; m_cause = 0; m_tval = 0; m_target = 0;
  endtask

  task automatic model_step();
    logic [63:0] p, d;
    int code;
    bit start;
    if (m_phase == 0) begin
      p = m_mip & m_mie & (m_ie ? ~64'h0 : 64'h0);
      code = m_prio(p);
      start = 0;
      if (exception_i) begin
        m_is_ret = 0; m_cause = 64'(exception_cause_i); m_tval = exception_tval_i; start = 1;
      end else if (code >= 0) begin
        m_is_ret = 0; m_cause = (64'h1 << 63) | 64'(code); m_tval = 0; start = 1;
      end else if (mret_i) begin
        m_is_ret = 1; start = 1;
      end
      d = csr_write_data_i;
      if ((csr_command_i == 2'b10 || csr_command_i == 2'b11) && m_impl(csr_address_i) && !exception_i) begin
        case (csr_address_i)
          12'h300: begin m_ie = d[3]; m_pie = d[7]; end
          12'h304: m_mie = d & 64'h000F_0888;
          12'h305: begin
            m_tvec_base = d & ~64'h3;
`ifdef MTVEC_VECTORED_EN
            if (d[1:0] < 2) m_tvec_mode = d[0];
`endif
          end
          12'h340: m_mscratch = d;
          12'h341: m_mepc = d & ~64'h3;
          12'h342: m_mcause = d;
          12'h343: m_mtval = d;
          default: ;
        endcase
      end
      m_phase = start ? 1 : 0;
    end else if (m_phase == 1) begin
      if (m_is_ret) begin
        m_ie = m_pie; m_pie = 1; m_target = m_mepc;
      end else begin
        m_mepc = commit_pc_i & ~64'h3; m_mcause = m_cause; m_mtval = m_tval;
        m_pie = m_ie; m_ie = 0;
        if (m_cause[63] && m_tvec_mode) m_target = m_tvec_base + 4 * (m_cause & 64'h1F);
        else                            m_target = m_tvec_base;
      end
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
    m_mip = 0;
    m_mip[3] = irq_i[0]; m_mip[7] = irq_i[1]; m_mip[11] = irq_i[2];
    for (int i = 0; i < NL; i++) m_mip[16+i] = local_irq_i[i];
  endtask

  // Compare process: outputs of the current cycle, then advance the model.
  initial begin
    model_reset();
    forever begin
      logic [63:0] exp_rd;
      @(negedge clock_i);
      if (!reset_ni) model_reset();
      check("busy", 64'(busy_o), 64'(m_phase != 0));
      check("trap_taken", 64'(trap_taken_o), 64'(m_phase == 2));
      if (m_phase == 2) check("trap_pc", trap_pc_o, m_target);
      if (!reset_ni)    check("trap_pc_reset", trap_pc_o, 64'h0);
      exp_rd = ((csr_command_i == 2'b01 || csr_command_i == 2'b11) && m_impl(csr_address_i) && m_phase == 0)
               ? m_read(csr_address_i) : 64'h0;
      check("read_data", csr_read_data_o, exp_rd);
      check("read_valid", 64'(csr_read_data_valid_o), 64'(m_impl(csr_address_i) && m_phase == 0));
      check("illegal", 64'(csr_illegal_o), 64'(csr_command_i != 2'b00 && !m_impl(csr_address_i)));
      if (reset_ni) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_command_i = 2'b10; csr_address_i = a; csr_write_data_i = d;
    tick();
    csr_command_i = 2'b00;
  endtask

  task automatic csr_expect(input string name, input logic [11:0] a, input logic [63:0] exp);
    csr_command_i = 2'b01; csr_address_i = a;
    @(negedge clock_i); #1;
    check(name, csr_read_data_o, exp);
    tick();
    csr_command_i = 2'b00;
  endtask

  task automatic wait_pulse(input string name, input logic [63:0] exp_pc, input int exp_n);
    bit found;
    found = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock_i); #1;
      if (trap_taken_o) begin
        check({name, "_pc"}, trap_pc_o, exp_pc);
        check({name, "_latency"}, 64'(n), 64'(exp_n));
        found = 1;
        break;
      end
    end
    if (!found) check({name, "_timeout"}, 64'(trap_taken_o), 64'h1);
    tick();
  endtask

  logic [11:0] addr_list [12] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'h7C0, 12'h302, 12'hF14};

  initial begin
    // 1: reset state
    repeat (3) @(posedge clock_i);
    @(negedge clock_i); #1;
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_taken", 64'(trap_taken_o), 64'h0);
    check("rst_pc", trap_pc_o, 64'h0);
    tick();
    reset_ni = 1'b1;
    tick();
    csr_command_i = 2'b01; csr_address_i = 12'h305;
    @(negedge clock_i); #1;
    check("mtvec_reset", csr_read_data_o, 64'h8000_0000);
    check("mtvec_valid", 64'(csr_read_data_valid_o), 64'h1);
    tick();
    csr_address_i = 12'h7C0;
    @(negedge clock_i); #1;
    check("unimpl_data", csr_read_data_o, 64'h0);
    check("unimpl_valid", 64'(csr_read_data_valid_o), 64'h0);
    check("unimpl_illegal", 64'(csr_illegal_o), 64'h1);
    tick();
    csr_command_i = 2'b00;
    csr_expect("misa", 12'h301, 64'h8000_0000_0000_0100);
    csr_expect("mstatus_reset", 12'h300, 64'h1800);

    // 2: exception entry
    csr_write(12'h305, 64'h1000);
    commit_pc_i = 64'h2004; exception_i = 1; exception_cause_i = 5'd2; exception_tval_i = 64'hDEAD;
    tick();
    exception_i = 0;
    wait_pulse("exc", 64'h1000, 1);
    csr_expect("exc_mepc", 12'h341, 64'h2004);
    csr_expect("exc_mcause", 12'h342, 64'h2);
    csr_expect("exc_mtval", 12'h343, 64'hDEAD);

    // 3: interrupt entry, MEI wins
    csr_write(12'h300, 64'h8);
    csr_write(12'h304, 64'h888);
    commit_pc_i = 64'h3000;
    irq_i = 3'b111;
    tick();
    wait_pulse("irq", 64'h1000, 2);
    csr_expect("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    csr_expect("irq_mtval", 12'h343, 64'h0);
    csr_expect("irq_mstatus", 12'h300, 64'h1880);

    // 4: MRET then re-entry with lines still high
    mret_i = 1;
    tick();
    mret_i = 0;
    wait_pulse("mret", 64'h3000, 1);
    csr_expect("mret_mstatus", 12'h300, 64'h1888);
    wait_pulse("reentry", 64'h1000, 1);
    irq_i = 3'b000;
    tick();

    // 5: exception beats MRET and a local irq in the same cycle
    csr_write(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_expect("mie_mask", 12'h304, 64'h000F_0888);
    csr_write(12'h300, 64'h8);
    local_irq_i = 4'b0100;
    commit_pc_i = 64'h4000;
    tick();
    exception_i = 1; mret_i = 1; exception_cause_i = 5'd5; exception_tval_i = 64'h55;
    tick();
    exception_i = 0; mret_i = 0;
    wait_pulse("race", 64'h1000, 1);
    csr_expect("race_mcause", 12'h342, 64'h5);
    csr_expect("race_mepc", 12'h341, 64'h4000);

    // 6: vectored (or not) local interrupt 2
    csr_write(12'h305, 64'h1001);
`ifdef MTVEC_VECTORED_EN
    csr_expect("mtvec_mode1", 12'h305, 64'h1001);
    csr_write(12'h300, 64'h8);
    wait_pulse("local", 64'h1048, 2);
`else
    csr_expect("mtvec_mode1", 12'h305, 64'h1000);
    csr_write(12'h300, 64'h8);
    wait_pulse("local", 64'h1000, 2);
`endif
    csr_expect("local_mcause", 12'h342, 64'h8000_0000_0000_0012);
    local_irq_i = 4'b0000;
    csr_write(12'h305, 64'h2002);
`ifdef MTVEC_VECTORED_EN
    csr_expect("mtvec_mode2", 12'h305, 64'h2001);
`else
    csr_expect("mtvec_mode2", 12'h305, 64'h2000);
`endif
    csr_write(12'h341, 64'h7777);
    csr_expect("mepc_write", 12'h341, 64'h7774);

    // 7: reset in the middle of a trap entry
    commit_pc_i = 64'h5000; exception_i = 1; exception_cause_i = 5'd7;
    tick();
    exception_i = 0;
    #2 reset_ni = 1'b0;
    @(negedge clock_i); #1;
    check("midrst_busy", 64'(busy_o), 64'h0);
    check("midrst_taken", 64'(trap_taken_o), 64'h0);
    tick();
    reset_ni = 1'b1;
    csr_expect("midrst_mepc", 12'h341, 64'h0);
    csr_expect("midrst_mcause", 12'h342, 64'h0);
    csr_expect("midrst_mtvec", 12'h305, 64'h8000_0000);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      csr_command_i    = 2'($urandom_range(0, 3));
      csr_address_i    = addr_list[$urandom_range(0, 11)];
      csr_write_data_i = {$urandom, $urandom};
      if (m_phase == 0) begin
        exception_i       = ($urandom_range(0, 19) == 0);
        mret_i            = ($urandom_range(0, 14) == 0);
        exception_cause_i = 5'($urandom_range(0, 31));
        exception_tval_i  = {$urandom, $urandom};
        commit_pc_i       = {$urandom, $urandom};
      end else begin
        exception_i = 0;
        mret_i      = 0;
      end
      if ($urandom_range(0, 7) == 0) irq_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) local_irq_i = 4'($urandom_range(0, 15));
      tick();
    end
    csr_command_i = 0; exception_i = 0; mret_i = 0; irq_i = 0; local_irq_i = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
